bk_operand_feeder: RTL and testbench

Upstream feeder stage for the 12-bit combinational Brent-Kung adder. It accepts (A, B) operand pairs over a valid/ready handshake, buffers them in a small FIFO, and drives the adder's 24-bit interleaved operand bus from the FIFO head. It registers the adder's 13-bit sum into an output register, presented to the consumer over a second valid/ready handshake. It sustains one addition per cycle under no backpressure.

---
 rtl/bk_operand_feeder.sv | 170 +++++++++++++++++
 tb/tb_bk_operand_feeder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bk_operand_feeder.sv
// Operand feeder for the 12-bit Brent-Kung adder: FIFO-buffered operand pairs in, registered sums out.
// Optional carry flag (sticky_clr/carry_sticky) is built when BKF_STICKY_CARRY_EN is defined.
module bk_operand_feeder #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic [2*WIDTH-1:0]   adder_in,
  input  logic [WIDTH:0]       adder_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH:0]       out_sum,
  output logic [15:0]          txn_count
`ifdef BKF_STICKY_CARRY_EN
  ,
  input  logic                 sticky_clr,
  output logic                 carry_sticky
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [2*WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH:0]     r_out_sum;
  logic [15:0]        r_txn_count;

  logic               w_empty;
  logic               w_push;
  logic               w_capture;
  logic               w_consume;
  logic [CW-1:0]      w_count_nxt;
  logic [2*WIDTH-1:0] w_head;

  function automatic logic [2*WIDTH-1:0] interleave(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[2*i]   = a[i];
      r[2*i+1] = b[i];
    end
    return r;
  endfunction

  assign w_empty   = (r_count == '0);
  assign w_push    = in_valid & r_in_ready;
  assign w_capture = !w_empty & (!r_out_valid | out_ready);
  assign w_consume = r_out_valid & out_ready;
  assign w_head    = r_mem[r_rd_ptr];

  // Occupancy after this edge; push and pop together cancel out.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_capture})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Adder operands come straight from the head slot, zeroed when nothing is buffered.
  always_comb begin
    if (w_empty) begin
      adder_in = '0;
    end else begin
      adder_in = interleave(w_head[2*WIDTH-1:WIDTH], w_head[WIDTH-1:0]);
    end
  end

  // Operand storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= {in_a, in_b};
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // Pointers, occupancy and the registered full decode. in_ready stays low until
  // the first edge after reset release because it is loaded only on clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_capture) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != CW'(DEPTH));
    end
  end

  // Result register: capture wins over consume so back-to-back results keep out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= adder_out;
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= r_out_sum;
    end else begin
      r_out_valid <= r_out_valid;
      r_out_sum   <= r_out_sum;
    end
  end

  // Consumed-result counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txn_count <= 16'h0000;
    end else if (w_consume) begin
      r_txn_count <= r_txn_count + 16'h0001;
    end else begin
      r_txn_count <= r_txn_count;
    end
  end

`ifdef BKF_STICKY_CARRY_EN
  logic r_carry_sticky;

  // Set has priority over clear so a carry captured during a clear is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry_sticky <= 1'b0;
    end else if (w_capture & adder_out[WIDTH]) begin
      r_carry_sticky <= 1'b1;
    end else if (sticky_clr) begin
      r_carry_sticky <= 1'b0;
    end else begin
      r_carry_sticky <= r_carry_sticky;
    end
  end

  assign carry_sticky = r_carry_sticky;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign txn_count = r_txn_count;

endmodule

// File: tb/tb_bk_operand_feeder.sv
// Self-checking bench for bk_operand_feeder: vector table, directed corner sequences and
// randomized traffic against a queue-based reference of accepted pairs.
module tb_bk_operand_feeder;
  localparam int WIDTH = 12;
  localparam int DEPTH = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [2*WIDTH-1:0] adder_in;
  logic [WIDTH:0]     adder_out;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH:0]     out_sum;
  logic [15:0]        txn_count;
  logic               sticky_clr;
`ifdef BKF_STICKY_CARRY_EN
  logic               carry_sticky;
`endif

  always #5 clk = ~clk;

  bk_operand_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .adder_in(adder_in), .adder_out(adder_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .txn_count(txn_count)
`ifdef BKF_STICKY_CARRY_EN
    , .sticky_clr(sticky_clr), .carry_sticky(carry_sticky)
`endif
  );

  // Stand-in for the combinational adder: undo the interleave and add.
  logic [WIDTH-1:0] ma, mb;
  always_comb begin
    ma = '0;
    mb = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ma[i] = adder_in[2*i];
      mb[i] = adder_in[2*i+1];
    end
    adder_out = {1'b0, ma} + {1'b0, mb};
  end

  typedef struct {
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] ain;
    logic [WIDTH:0]     sum;
  } vec_t;
  vec_t vecs[5];

  int             n_tests = 0;
  int             n_fail  = 0;
  logic [WIDTH:0] exp_q[$];
  int             consumed = 0;
  logic           prev_hold = 1'b0;
  logic [WIDTH:0] prev_sum = '0;
  int             tick_no = 0;
  int             ov_cycles = 0;
  int             first_ov = -1;
  int             last_ov = -1;
  int             accepted = 0;
  logic [WIDTH:0] s1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, observe, predict, then advance to the next falling edge.
  task automatic tick(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic rdy);
    logic push, pop;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    out_ready = rdy;
    #1;
    push = in_valid & in_ready;
    pop  = out_valid & out_ready;
    if (prev_hold) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_sum", 32'(out_sum), 32'(prev_sum));
    end
    if (pop) begin
      if (exp_q.size() == 0) chk("spurious_result", 32'(out_valid), 32'd0);
      else chk("out_sum_order", 32'(out_sum), 32'(exp_q.pop_front()));
      consumed++;
    end
    if (push) begin
      exp_q.push_back({1'b0, a} + {1'b0, b});
      chk("pending_bound", 32'(exp_q.size() <= DEPTH + 1), 32'd1);
    end
    if (out_valid) begin
      ov_cycles++;
      last_ov = tick_no;
      if (first_ov < 0) first_ov = tick_no;
    end
    prev_hold = out_valid & !out_ready;
    prev_sum  = out_sum;
    tick_no++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_sum"}, 32'(out_sum), 32'd0);
    chk({tag, "_txn_count"}, 32'(txn_count), 32'd0);
    chk({tag, "_adder_in"}, 32'(adder_in), 32'd0);
`ifdef BKF_STICKY_CARRY_EN
    chk({tag, "_sticky"}, 32'(carry_sticky), 32'd0);
`endif
  endtask

  // Asynchronous reset pulse mid-cycle; the model discards everything in flight.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    exp_q.delete();
    consumed  = 0;
    prev_hold = 1'b0;
    in_valid  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_edge", 32'(in_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{a: 12'hFFF, b: 12'h001, ain: 24'h555557, sum: 13'h1000};
    vecs[1] = '{a: 12'h000, b: 12'h000, ain: 24'h000000, sum: 13'h0000};
    vecs[2] = '{a: 12'hFFF, b: 12'hFFF, ain: 24'hFFFFFF, sum: 13'h1FFE};
    vecs[3] = '{a: 12'hAAA, b: 12'h555, ain: 24'h666666, sum: 13'h0FFF};
    vecs[4] = '{a: 12'h800, b: 12'h800, ain: 24'hC00000, sum: 13'h1000};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    out_ready  = 1'b0;
    sticky_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_edge", 32'(in_ready), 32'd1);

    // Vector table: one pair at a time, checking interleave, latency and sum.
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, vecs[i].a, vecs[i].b, 1'b1);
      chk("adder_in_head", 32'(adder_in), 32'(vecs[i].ain));
      chk("no_early_valid", 32'(out_valid), 32'd0);
      tick(1'b0, '0, '0, 1'b1);
      chk("latency_valid", 32'(out_valid), 32'd1);
      chk("vec_out_sum", 32'(out_sum), 32'(vecs[i].sum));
      chk("adder_in_empty", 32'(adder_in), 32'd0);
`ifdef BKF_STICKY_CARRY_EN
      if (i == 0) chk("sticky_single_add", 32'(carry_sticky), 32'd1);
`endif
      tick(1'b0, '0, '0, 1'b1);
      chk("txn_count_vec", 32'(txn_count), 32'(16'(consumed)));
    end

    // Streaming: 16 back-to-back pairs, expect 16 consecutive valid cycles.
    tick_no   = 0;
    ov_cycles = 0;
    first_ov  = -1;
    last_ov   = -1;
    for (int i = 0; i < 16; i++) begin
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      tick(1'b1, WIDTH'(i), WIDTH'(2 * i), 1'b1);
    end
    repeat (3) tick(1'b0, '0, '0, 1'b1);
    chk("stream_valid_cycles", 32'(ov_cycles), 32'd16);
    chk("stream_consecutive", 32'(last_ov - first_ov + 1), 32'd16);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: DEPTH pairs plus one result fit, the fourth is refused.
    accepted = 0;
    for (int k = 0; k < 4; k++) begin
      if (in_ready) accepted++;
      tick(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b0);
    end
    chk("bp_accepted", 32'(accepted), 32'd3);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    repeat (5) tick(1'b0, '0, '0, 1'b1);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Simultaneous push/pop and consume/capture at one-below-full.
    tick(1'b1, 12'h111, 12'h222, 1'b0);
    tick(1'b1, 12'h345, 12'h0CB, 1'b0);
    s1 = {1'b0, 12'h345} + {1'b0, 12'h0CB};
    chk("sim_pre_valid", 32'(out_valid), 32'd1);
    chk("sim_pre_in_ready", 32'(in_ready), 32'd1);
    tick(1'b1, 12'h700, 12'h0FF, 1'b1);
    chk("sim_valid_kept", 32'(out_valid), 32'd1);
    chk("sim_next_sum", 32'(out_sum), 32'(s1));
    chk("sim_occupancy_kept", 32'(in_ready), 32'd1);
    repeat (3) tick(1'b0, '0, '0, 1'b1);
    chk("sim_drained", 32'(exp_q.size()), 32'd0);

    // Reset with two pairs buffered and a pending result; nothing old may reappear.
    repeat (3) tick(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b0);
    chk("mid_pending_valid", 32'(out_valid), 32'd1);
    async_reset();
    repeat (4) tick(1'b0, '0, '0, 1'b1);
    chk("mid_no_valid", 32'(out_valid), 32'd0);
    chk("mid_txn_zero", 32'(txn_count), 32'd0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      tick(1'($urandom_range(0, 1)), WIDTH'($urandom), WIDTH'($urandom),
           1'($urandom_range(0, 3) != 0));
    end
    repeat (6) tick(1'b0, '0, '0, 1'b1);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_txn_count", 32'(txn_count), 32'(16'(consumed)));

`ifdef BKF_STICKY_CARRY_EN
    sticky_clr = 1'b1;
    tick(1'b0, '0, '0, 1'b1);
    sticky_clr = 1'b0;
    chk("sticky_cleared", 32'(carry_sticky), 32'd0);
    tick(1'b1, 12'hFFF, 12'h001, 1'b1);
    sticky_clr = 1'b1;
    tick(1'b0, '0, '0, 1'b1);
    sticky_clr = 1'b0;
    chk("sticky_set_beats_clr", 32'(carry_sticky), 32'd1);
    sticky_clr = 1'b1;
    tick(1'b0, '0, '0, 1'b1);
    sticky_clr = 1'b0;
    chk("sticky_cleared_again", 32'(carry_sticky), 32'd0);
`endif

    // Counter wrap: exactly 65536 handshakes from a fresh reset.
    async_reset();
    for (int k = 0; k < 65536; k++) tick(1'b1, '0, '0, 1'b1);
    repeat (3) tick(1'b0, '0, '0, 1'b1);
    chk("wrap_handshakes", 32'(consumed), 32'd65536);
    chk("wrap_txn_count", 32'(txn_count), 32'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
